// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU control path:
//   - default data / opcode widths
//   - opcode constants (taken from ir[7:4])
//   - sequencer state encoding (3-bit)
//   - ALU operation and jump-condition encodings
//   - decoded-instruction control bundle and a jump-resolution helper
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPC_W  = 4;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDI = 4'h1;
  localparam opcode_t OP_ADD = 4'h2;
  localparam opcode_t OP_SUB = 4'h3;
  localparam opcode_t OP_JMP = 4'h4;
  localparam opcode_t OP_JZ  = 4'h5;
  localparam opcode_t OP_JNZ = 4'h6;
  localparam opcode_t OP_HLT = 4'hF;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH     = 3'd0;
  localparam state_t S_WAIT_INS  = 3'd1;
  localparam state_t S_DECODE    = 3'd2;
  localparam state_t S_FETCH_IMM = 3'd3;
  localparam state_t S_WAIT_IMM  = 3'd4;
  localparam state_t S_EXEC      = 3'd5;
  localparam state_t S_HALT      = 3'd6;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    JC_NONE   = 2'd0,
    JC_ALWAYS = 2'd1,
    JC_ZERO   = 2'd2,
    JC_NZERO  = 2'd3
  } jump_cond_t;

  // Everything the sequencer needs to know about an opcode.
  typedef struct packed {
    logic       is_two_byte;
    logic       is_halt;
    logic       is_jump;
    jump_cond_t jump_cond;
    logic       acc_ld;
    logic       acc_src;
    alu_op_t    alu_op;
    logic       illegal;
  } decode_t;

  // Resolves a jump condition against the accumulator zero flag.
  function automatic logic jump_taken(jump_cond_t cond, logic zero);
    case (cond)
      JC_ALWAYS: return 1'b1;
      JC_ZERO:   return zero;
      JC_NZERO:  return ~zero;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
// Instruction-memory read handshake between the fetch sequencer and memory.
//   mem_rd    : read request, held by the sequencer until mem_ready
//   mem_ready : read data valid this cycle
//   mem_data  : read data
// Modports: master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int DATA_W = cpu_pkg::DEF_DATA_W
) ();

  logic              mem_rd;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output mem_rd,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    output mem_ready,
    output mem_data
  );

endinterface

// File: rtl/fetch_sequencer_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
// Purely combinational opcode decoder for the fetch sequencer.
//   opcode : upper nibble of the instruction register
//   dec    : control bundle (length, halt, jump kind, accumulator/ALU
//            controls, illegal flag)
// Opcodes 7..E are undefined: they behave as NOP and raise `illegal`.
// ----------------------------------------------------------------------------
module instr_decode
  import cpu_pkg::*;
(
  input  opcode_t opcode,
  output decode_t dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // bit unassigned, which would otherwise infer a latch.
    dec           = '0;
    dec.alu_op    = ALU_PASS;
    dec.jump_cond = JC_NONE;
    case (opcode)
      OP_NOP: ;
      OP_LDI: begin
        dec.is_two_byte = 1'b1;
        dec.acc_ld      = 1'b1;
        dec.acc_src     = 1'b1;
      end
      OP_ADD: begin
        dec.acc_ld = 1'b1;
        dec.alu_op = ALU_ADD;
      end
      OP_SUB: begin
        dec.acc_ld = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_JMP: begin
        dec.is_two_byte = 1'b1;
        dec.is_jump     = 1'b1;
        dec.jump_cond   = JC_ALWAYS;
      end
      OP_JZ: begin
        dec.is_two_byte = 1'b1;
        dec.is_jump     = 1'b1;
        dec.jump_cond   = JC_ZERO;
      end
      OP_JNZ: begin
        dec.is_two_byte = 1'b1;
        dec.is_jump     = 1'b1;
        dec.jump_cond   = JC_NZERO;
      end
      OP_HLT:  dec.is_halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Multi-cycle control FSM of the 8-bit CPU: fetches 1- or 2-byte
// instructions over a read/ready handshake, holds the instruction and
// immediate bytes, and strobes the PC, accumulator and ALU.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   pc_value    : current PC (address presented to memory, not needed here)
//   mem_bus     : instruction memory handshake (master side)
//   zero_flag   : accumulator == 0, sampled in EXEC only
//   resume      : leaves HALT (level, sampled in HALT only)
//   pc_enable   : one-cycle PC increment, issued on each accepted byte
//   pc_ld       : one-cycle PC load with pc_inp (taken jumps)
//   pc_inp      : jump target (the immediate byte)
//   ir, imm     : instruction and immediate bytes
//   alu_op      : 00 pass, 01 add, 10 sub (valid with acc_ld)
//   acc_ld      : one-cycle accumulator write, acc_src 0=ALU / 1=imm
//   halted      : high while in HALT
//   illegal_op  : one-cycle pulse in EXEC of an undefined opcode
// ----------------------------------------------------------------------------
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  pc_value,
  fetch_sequencer_if.master  mem_bus,
  input  logic               zero_flag,
  input  logic               resume,
  output logic               pc_enable,
  output logic               pc_ld,
  output logic [DATA_W-1:0]  pc_inp,
  output logic [DATA_W-1:0]  ir,
  output logic [DATA_W-1:0]  imm,
  output logic [1:0]         alu_op,
  output logic               acc_ld,
  output logic               acc_src,
  output logic               halted,
  output logic               illegal_op
);

  state_t  state;
  state_t  state_nx;
  decode_t dec;
  logic    mem_rd_st;

  // The PC itself is owned by program_counter; its value is observational.
  logic unused_pc_value;
  assign unused_pc_value = ^pc_value;

  instr_decode u_decode (
    .opcode (opcode_t'(ir[DATA_W-1 -: OPC_W])),
    .dec    (dec)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Instruction and immediate bytes are captured on the accepted beat only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir  <= '0;
      imm <= '0;
    end else begin
      if (state == S_WAIT_INS && mem_bus.mem_ready) ir  <= mem_bus.mem_data;
      if (state == S_WAIT_IMM && mem_bus.mem_ready) imm <= mem_bus.mem_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:     state_nx = S_WAIT_INS;
      S_WAIT_INS:  if (mem_bus.mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (dec.is_two_byte)  state_nx = S_FETCH_IMM;
        else if (dec.is_halt) state_nx = S_HALT;
        else                  state_nx = S_EXEC;
      end
      S_FETCH_IMM: state_nx = S_WAIT_IMM;
      S_WAIT_IMM:  if (mem_bus.mem_ready) state_nx = S_EXEC;
      S_EXEC:      state_nx = S_FETCH;
      S_HALT:      if (resume) state_nx = S_FETCH;
      default:     state_nx = S_FETCH;
    endcase
  end

  // Output logic. Strobes depend on the current state only, plus mem_ready in
  // the wait states, so mem_ready elsewhere has no effect.
  always_comb begin
    mem_rd_st  = 1'b0;
    pc_enable  = 1'b0;
    pc_ld      = 1'b0;
    alu_op     = ALU_PASS;
    acc_ld     = 1'b0;
    acc_src    = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH, S_FETCH_IMM: mem_rd_st = 1'b1;
      S_WAIT_INS, S_WAIT_IMM: begin
        mem_rd_st = 1'b1;
        pc_enable = mem_bus.mem_ready;
      end
      S_EXEC: begin
        acc_ld     = dec.acc_ld;
        acc_src    = dec.acc_src;
        alu_op     = dec.alu_op;
        pc_ld      = dec.is_jump && jump_taken(dec.jump_cond, zero_flag);
        illegal_op = dec.illegal;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Reset parks the FSM in FETCH, which would otherwise already request a
  // read; the request only starts once reset is released.
  assign mem_bus.mem_rd = mem_rd_st & ~reset;

  // The jump target is always the immediate byte.
  assign pc_inp = imm;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Plays program_counter and instruction memory around the sequencer. Each
// instruction is executed against a per-instruction expectation derived from
// the instruction-level rules (byte count, wait cycles, EXEC effects), and
// the bench's own PC follows the expected increments and jumps.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

  typedef struct packed {
    logic       mem_rd;
    logic       pc_enable;
    logic       pc_ld;
    logic       acc_ld;
    logic       acc_src;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal_op;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic       zero_flag;
  logic       resume;
  logic       pc_enable;
  logic       pc_ld;
  logic [7:0] pc_inp;
  logic [7:0] ir;
  logic [7:0] imm;
  logic [1:0] alu_op;
  logic       acc_ld;
  logic       acc_src;
  logic       halted;
  logic       illegal_op;

  logic [7:0] mem [256];
  logic [7:0] imm_exp;
  int         checks = 0;
  int         errors = 0;

  fetch_sequencer_if #(.DATA_W(8)) bus ();

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pc_value   (pc),
    .mem_bus    (bus),
    .zero_flag  (zero_flag),
    .resume     (resume),
    .pc_enable  (pc_enable),
    .pc_ld      (pc_ld),
    .pc_inp     (pc_inp),
    .ir         (ir),
    .imm        (imm),
    .alu_op     (alu_op),
    .acc_ld     (acc_ld),
    .acc_src    (acc_src),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic outs_t dut_outs();
    return {bus.mem_rd, pc_enable, pc_ld, acc_ld, acc_src, alu_op, halted, illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the
  // bench PC the way program_counter would.
  task automatic cycle(input string tag, input logic rdy, input logic zf,
                       input logic res, input outs_t e, input logic [7:0] inp_exp);
    bus.mem_ready = rdy;
    bus.mem_data  = rdy ? mem[pc] : 8'($urandom);
    zero_flag     = zf;
    resume        = res;
    @(negedge clk);
    check(tag, 32'(dut_outs()), 32'(e));
    if (e.pc_ld) check({tag, ".pc_inp"}, 32'(pc_inp), 32'(inp_exp));
    @(posedge clk);
    #1;
    if (e.pc_enable)  pc = pc + 8'd1;
    else if (e.pc_ld) pc = inp_exp;
  endtask

  // Fetch one byte: request cycle, wait_force (or random 0..2) stalls,
  // then the accepted beat with its PC increment.
  task automatic handshake(input string tag, input int wait_force);
    outs_t e;
    int    w;
    w = (wait_force < 0) ? int'($urandom_range(0, 2)) : wait_force;
    e = '0;
    e.mem_rd = 1'b1;
    cycle({tag, ".fetch"}, rb(), rb(), rb(), e, 8'h00);
    repeat (w) cycle({tag, ".wait"}, 1'b0, rb(), rb(), e, 8'h00);
    e.pc_enable = 1'b1;
    cycle({tag, ".ready"}, 1'b1, rb(), rb(), e, 8'h00);
  endtask

  // Execute the instruction at pc. zf_force: 0/1 fixed, 2 random.
  task automatic run_instr(input int wait_force, input int zf_force, input int halt_len);
    logic [7:0] ins;
    logic [3:0] op;
    logic       zf;
    outs_t      e;
    ins = mem[pc];
    op  = ins[7:4];
    handshake("ins", wait_force);
    check("ir", 32'(ir), 32'(ins));
    e = '0;
    cycle("decode", rb(), rb(), rb(), e, 8'h00);
    if (op inside {4'h1, 4'h4, 4'h5, 4'h6}) begin
      imm_exp = mem[pc];
      handshake("imm", wait_force);
      check("imm", 32'(imm), 32'(imm_exp));
    end
    if (op == 4'hF) begin
      e = '0;
      e.halted = 1'b1;
      repeat (halt_len) cycle("halt", rb(), rb(), 1'b0, e, 8'h00);
      cycle("resume", rb(), rb(), 1'b1, e, 8'h00);
      return;
    end
    zf = (zf_force == 2) ? rb() : zf_force[0];
    e = '0;
    e.acc_ld     = op inside {4'h1, 4'h2, 4'h3};
    e.acc_src    = (op == 4'h1);
    e.alu_op     = (op == 4'h2) ? 2'b01 : (op == 4'h3) ? 2'b10 : 2'b00;
    e.pc_ld      = (op == 4'h4) || (op == 4'h5 && zf) || (op == 4'h6 && !zf);
    e.illegal_op = op inside {[4'h7:4'hE]};
    cycle("exec", rb(), zf, rb(), e, imm_exp);
  endtask

  initial begin
    outs_t e;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h00;                       // NOP
    mem[8'h01] = 8'h1A; mem[8'h02] = 8'h3C;   // LDI 3C
    mem[8'h03] = 8'h40; mem[8'h04] = 8'h18;   // JMP 18
    mem[8'h18] = 8'h50; mem[8'h19] = 8'h30;   // JZ 30 (not taken)
    mem[8'h1A] = 8'h50; mem[8'h1B] = 8'h30;   // JZ 30 (taken)
    mem[8'h30] = 8'h60; mem[8'h31] = 8'h40;   // JNZ 40 (not taken)
    mem[8'h32] = 8'h60; mem[8'h33] = 8'h40;   // JNZ 40 (taken)
    mem[8'h40] = 8'h20;                       // ADD, slow memory
    mem[8'h41] = 8'h30;                       // SUB
    mem[8'h42] = 8'h20;                       // ADD, cut by reset
    mem[8'h50] = 8'h70;                       // undefined
    mem[8'h51] = 8'hF0;                       // HLT
    mem[8'h52] = 8'h40; mem[8'h53] = 8'h52;   // JMP to itself

    pc            = 8'h00;
    imm_exp       = 8'h00;
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_data  = 8'h00;
    zero_flag     = 1'b0;
    resume        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", 32'(dut_outs()), 32'h0);
    check("reset.ir", 32'(ir), 32'h0);
    check("reset.imm", 32'(imm), 32'h0);
    check("reset.pc_inp", 32'(pc_inp), 32'h0);
    reset = 1'b0;

    run_instr(0, 2, 1);   // NOP
    run_instr(0, 2, 1);   // LDI 3C
    run_instr(0, 2, 1);   // JMP 18
    check("jmp.target", 32'(pc), 32'h18);
    run_instr(0, 0, 1);   // JZ, zero clear
    run_instr(0, 1, 1);   // JZ, zero set
    run_instr(0, 1, 1);   // JNZ, zero set
    run_instr(0, 0, 1);   // JNZ, zero clear
    run_instr(3, 2, 1);   // ADD with three stalls
    run_instr(0, 2, 1);   // SUB

    // Reset during the second stall of a fetch, with data arriving.
    e = '0;
    e.mem_rd = 1'b1;
    cycle("rst.fetch", 1'b0, rb(), rb(), e, 8'h00);
    cycle("rst.wait1", 1'b0, rb(), rb(), e, 8'h00);
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem[pc];
    #2;
    reset = 1'b1;
    #1;
    check("rst.async_outs", 32'(dut_outs()), 32'h0);
    check("rst.ir", 32'(ir), 32'h0);
    check("rst.imm", 32'(imm), 32'h0);
    check("rst.pc_inp", 32'(pc_inp), 32'h0);
    @(posedge clk);
    #1;
    check("rst.hold_outs", 32'(dut_outs()), 32'h0);
    reset   = 1'b0;
    pc      = 8'h50;
    imm_exp = 8'h00;

    run_instr(0, 2, 1);   // undefined opcode
    run_instr(0, 2, 5);   // HLT for five cycles, then resume
    run_instr(1, 2, 1);   // JMP to own address
    check("self_jmp.target", 32'(pc), 32'h52);

    // Random programs, random stalls, random flags and halt lengths.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 150; n++) run_instr(-1, 2, int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
